// File: rtl/mdu_64bit.sv
// -----------------------------------------------------------------------------
// mdu_64bit -- iterative 64-bit multiply/divide unit
//
// One radix-2 step per cycle: shift-add multiply or restoring divide on operand
// magnitudes, followed by a sign-correction/finish cycle. The fixed latency is
// 65 cycles from the capture edge to the done pulse.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   start   request, sampled only while ready=1
//   op      000 MUL, 001 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//           (010/011 reserved, result 0)
//   a, b    operand / dividend, operand / divisor
//   ready   idle indicator (combinational from state)
//   busy    inverse of ready
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next done
//
// Configuration macro:
//   MDU_EARLY_OUT_EN  when defined, a divide by zero or a multiply with a zero
//                     operand skips CALC and finishes 1 cycle after capture.
// -----------------------------------------------------------------------------
module mdu_64bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;

    // Magnitude of a value, treating it as two's complement only when sgn=1.
    function automatic logic [63:0] mag64(input logic [63:0] x, input logic sgn);
        logic [63:0] m;
        if (sgn && x[63]) begin
            m = 64'd0 - x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [5:0]  cnt_r;
    logic [2:0]  op_r;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic [63:0] hi_r;      // product high half / partial remainder
    logic [63:0] lo_r;      // product low half (multiplier) / dividend->quotient
    logic [63:0] opnd_r;    // multiplicand / divisor magnitude
    logic        neg_q_r;
    logic        neg_r_r;
    logic        done_r;
    logic [63:0] result_r;

    logic        in_is_div_s;
    logic        in_is_mul_s;
    logic        in_signed_s;
    logic [64:0] mul_sum_s;
    logic [64:0] rem_sh_s;
    logic [64:0] rem_diff_s;
    logic        rem_ge_s;
    logic [63:0] result_s;

    assign in_is_div_s = op[2];
    assign in_is_mul_s = (op[2:1] == 2'b00);
    assign in_signed_s = op[2] & ~op[0];

`ifdef MDU_EARLY_OUT_EN
    logic early_s;
    assign early_s = (in_is_div_s && (b == 64'd0)) ||
                     (in_is_mul_s && ((a == 64'd0) || (b == 64'd0)));
`endif

    // Step datapath. The shifted remainder is always below twice the divisor,
    // so the borrow bit of the 65-bit difference alone tells whether it fits.
    assign mul_sum_s  = {1'b0, hi_r} + {1'b0, (lo_r[0] ? opnd_r : 64'd0)};
    assign rem_sh_s   = {hi_r, lo_r[63]};
    assign rem_diff_s = rem_sh_s - {1'b0, opnd_r};
    assign rem_ge_s   = ~rem_diff_s[64];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
`ifdef MDU_EARLY_OUT_EN
                    if (early_s) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = CALC;
                    end
`else
                    state_nxt_s = CALC;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 6'd63) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sign correction and special-case selection for the finish cycle.
    always_comb begin
        result_s = 64'd0;
        case (op_r)
            OP_MUL:   result_s = lo_r;
            OP_MULHU: result_s = hi_r;
            OP_DIV, OP_DIVU: begin
                if (b_r == 64'd0) begin
                    result_s = 64'hFFFF_FFFF_FFFF_FFFF;
                end else if (neg_q_r) begin
                    result_s = 64'd0 - lo_r;
                end else begin
                    result_s = lo_r;
                end
            end
            OP_REM, OP_REMU: begin
                if (b_r == 64'd0) begin
                    result_s = a_r;
                end else if (neg_r_r) begin
                    result_s = 64'd0 - hi_r;
                end else begin
                    result_s = hi_r;
                end
            end
            default:  result_s = 64'd0;
        endcase
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= 6'd0;
            op_r     <= 3'd0;
            a_r      <= 64'd0;
            b_r      <= 64'd0;
            hi_r     <= 64'd0;
            lo_r     <= 64'd0;
            opnd_r   <= 64'd0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 64'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        cnt_r   <= 6'd0;
                        hi_r    <= 64'd0;
                        neg_q_r <= in_signed_s & (a[63] ^ b[63]);
                        neg_r_r <= in_signed_s & a[63];
                        if (in_is_div_s) begin
                            lo_r   <= mag64(a, in_signed_s);
                            opnd_r <= mag64(b, in_signed_s);
                        end else begin
                            lo_r   <= b;
                            opnd_r <= a;
                        end
`ifdef MDU_EARLY_OUT_EN
                        // Skipped multiplies finish with a zero product.
                        if (early_s && in_is_mul_s) begin
                            lo_r <= 64'd0;
                        end
`endif
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + 6'd1;
                    if (op_r[2]) begin
                        if (rem_ge_s) begin
                            hi_r <= rem_diff_s[63:0];
                            lo_r <= {lo_r[62:0], 1'b1};
                        end else begin
                            hi_r <= rem_sh_s[63:0];
                            lo_r <= {lo_r[62:0], 1'b0};
                        end
                    end else begin
                        {hi_r, lo_r} <= {mul_sum_s, lo_r[63:1]};
                    end
                end
                FIN: begin
                    result_r <= result_s;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = (state_r == IDLE);
    assign busy   = ~ready;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mdu_64bit.sv
// -----------------------------------------------------------------------------
// tb_mdu_64bit -- scoreboard bench for mdu_64bit
//
// Stimulus pushes the hand-computed result and the cycle at which done must
// appear; an independent monitor pops and compares on every done pulse.
// While the unit is busy, start is held high with scrambled operands.
// -----------------------------------------------------------------------------
module tb_mdu_64bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;

    mdu_64bit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Rising-edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected capture-to-done latency.
    function automatic int lat(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        int  l;
        logic early;
        l = 65;
        early = (o[2] && (y == 64'd0)) || ((o[2:1] == 2'b00) && ((x == 64'd0) || (y == 64'd0)));
`ifdef MDU_EARLY_OUT_EN
        if (early) l = 1;
`else
        if (early) l = 65;
`endif
        return l;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check64({e.name, "_result"}, result, e.res);
                check_int({e.name, "_cycle"}, cyc, e.at);
            end
        end
    end

    // Drive a request at the current negedge; it is captured on the next edge.
    task automatic drive_op(input string name, input logic [2:0] o, input logic [63:0] x,
                            input logic [63:0] y, input logic [63:0] r);
        exp_t e;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e.res  = r;
        e.at   = cyc + 1 + lat(o, x, y);
        e.name = name;
        sb.push_back(e);
    endtask

    // Wait for ready (start stays high with junk operands meanwhile), then drive.
    task automatic issue(input string name, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] r);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 200) begin
            op = 3'($urandom_range(7, 0));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            n++;
            @(negedge clk);
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_issue_timeout: got ready=%b expected 1", name, ready);
        end else begin
            drive_op(name, o, x, y, r);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 64'd0;
        b     = 64'd0;
        repeat (2) @(negedge clk);
        check64("rst_ready",  {63'd0, ready},  64'd1);
        check64("rst_busy",   {63'd0, busy},   64'd0);
        check64("rst_done",   {63'd0, done},   64'd0);
        check64("rst_result", result,          64'd0);

        // First request is accepted on the first edge after reset release.
        rst = 1'b0;
        drive_op("mul_small", 3'b000, 64'h10, 64'h3, 64'h30);
        issue("mulhu_max",    3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        issue("mul_neg",      3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 64'hFFFF_FFFF_FFFF_FFFA);
        issue("mulhu_2p64",   3'b001, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1);
        issue("mul_zero_a",   3'b000, 64'h0, 64'h5, 64'h0);
        issue("mulhu_zero_b", 3'b001, 64'h5, 64'h0, 64'h0);
        issue("div_neg7_2",   3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD);
        issue("rem_neg7_2",   3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("divu_100_7",   3'b101, 64'd100, 64'd7, 64'd14);
        issue("remu_100_7",   3'b111, 64'd100, 64'd7, 64'd2);
        issue("div_7_neg2",   3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        issue("rem_7_neg2",   3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
        issue("div_by0",      3'b100, 64'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("rem_by0_neg",  3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB);
        issue("remu_by0",     3'b111, 64'h55, 64'h0, 64'h55);
        issue("divu_by0",     3'b101, 64'h55, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("div_ovf",      3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        issue("rem_ovf",      3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        issue("rsvd_010",     3'b010, 64'h7, 64'h9, 64'h0);
        issue("rsvd_011",     3'b011, 64'h7, 64'h9, 64'h0);
        issue("divu_max",     3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h5555_5555_5555_5555);
        drain();

        // Reset in the middle of an operation aborts it without a done pulse.
        issue("abort_op", 3'b101, 64'd1000, 64'd3, 64'd333);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        check64("abort_ready",  {63'd0, ready}, 64'd1);
        check64("abort_busy",   {63'd0, busy},  64'd0);
        check64("abort_done",   {63'd0, done},  64'd0);
        check64("abort_result", result,         64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check64("post_abort_result", result, 64'd0);

        // Back-to-back after the abort: early-out candidate then a signed remainder.
        issue("mul_zero_after", 3'b000, 64'h0, 64'h1234, 64'h0);
        issue("rem_after",      3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
